seg_scan_driver: RTL and testbench

- Parametrised multiplexed 7-segment display driver; next generation of the fixed 6-digit tick-driven segment mux.
- Internal scan divider, configurable digit count and drive polarities, hex-decode or raw-segment mode, per-digit decimal point, dead-time blanking against ghosting, and PWM brightness.
- Frame-synchronous shadow latching of display data, so a digit never changes mid-frame (no tearing).
- Sits between application logic and the Pmod 7-segment row/column pins.

---
 rtl/seg_scan_driver.sv | 93 +++++++++
 tb/tb_seg_scan_driver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with frame-latched shadows, dead-time blanking and PWM brightness
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 27000,
  parameter int BLANK_CYCLES   = 270,
  parameter int BRIGHT_W       = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [NUM_DIGITS*8-1:0] raw_seg,
  input  logic [NUM_DIGITS*4-1:0] hex_val,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_out,
  output logic [IW-1:0]           cur_digit,
  output logic                    frame_tick
);
  localparam logic [7:0] SEG_INV = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV = DIG_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [NUM_DIGITS*8-1:0] sh_raw;
  logic [NUM_DIGITS*4-1:0] sh_hex;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_mode;
  logic [BRIGHT_W-1:0]     sh_bright;
  logic                    slot_end, frame_end, on, dp_bit;
  logic [BRIGHT_W-1:0]     phase;
  logic [7:0]              raw_cur, seg_src;
  logic [3:0]              nib;
  always_comb begin
    slot_end  = slot_cnt == CW'(SCAN_DIV - 1);
    frame_end = en && slot_end && idx == IW'(NUM_DIGITS - 1);
    phase     = BRIGHT_W'(32'(slot_cnt) - 32'(BLANK_CYCLES));
    on        = en && 32'(slot_cnt) >= 32'(BLANK_CYCLES) && phase < sh_bright;
    raw_cur   = sh_raw[{idx, 3'b000} +: 8];
    nib       = sh_hex[{idx, 2'b00} +: 4];
    dp_bit    = sh_dp[idx];
    seg_src   = sh_mode ? {dp_bit, HEX[nib]} : {raw_cur[7] | dp_bit, raw_cur[6:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (!en) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end
  // Shadows track the inputs while idle so scanning starts with fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_raw    <= '0;
      sh_hex    <= '0;
      sh_dp     <= '0;
      sh_mode   <= 1'b0;
      sh_bright <= '0;
    end else if (!en || frame_end) begin
      sh_raw    <= raw_seg;
      sh_hex    <= hex_val;
      sh_dp     <= dp;
      sh_mode   <= mode;
      sh_bright <= brightness;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_INV;
      dig_out    <= DIG_INV;
      cur_digit  <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= (on ? seg_src : 8'h00) ^ SEG_INV;
      dig_out    <= (on ? NUM_DIGITS'(1) << idx : '0) ^ DIG_INV;
      cur_digit  <= en ? idx : '0;
      frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table-driven frames checked through an expectation queue, plus enable/reset corner sequences
module tb_seg_scan_driver;
  typedef struct packed {
    logic        mode;
    logic [15:0] hex;
    logic [31:0] raw;
    logic [3:0]  dp;
    logic [1:0]  bright;
    logic [3:0][7:0] seg;
  } rec_t;
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       tick;
    logic [1:0] cur;
    logic [7:0] k;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, mode = 1'b0;
  logic [31:0] raw_seg = '0;
  logic [15:0] hex_val = '0;
  logic [3:0]  dp = '0;
  logic [1:0]  brightness = '0;
  logic [7:0]  seg_out;
  logic [3:0]  dig_out;
  logic [1:0]  cur_digit;
  logic        frame_tick;
  int tests = 0, fails = 0;
  exp_t q[$];
  rec_t tbl [6];
  rec_t dark, upd;
  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BRIGHT_W(2),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .raw_seg(raw_seg), .hex_val(hex_val),
    .dp(dp), .brightness(brightness), .seg_out(seg_out), .dig_out(dig_out),
    .cur_digit(cur_digit), .frame_tick(frame_tick));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({seg_out, dig_out, frame_tick, cur_digit} !== {e.seg, e.dig, e.tick, e.cur}) begin
        fails++;
        $display("FAIL scan k=%0d seg=%h/%h dig=%b/%b tick=%b/%b cur=%0d/%0d", e.k,
                 seg_out, e.seg, dig_out, e.dig, frame_tick, e.tick, cur_digit, e.cur);
      end
    end
  end
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask
  task automatic apply(input rec_t r);
    mode = r.mode; hex_val = r.hex; raw_seg = r.raw; dp = r.dp; brightness = r.bright;
  endtask
  task automatic push_idle();
    q.push_back('{seg: 8'h00, dig: 4'hF, tick: 1'b0, cur: 2'd0, k: 8'hFF});
  endtask
  task automatic run_frame(input rec_t r, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      int cnt, di;
      logic on;
      cnt = k % 8;
      di = k / 8;
      on = cnt >= 2 && ((cnt - 2) % 4) < int'(r.bright);
      q.push_back('{seg: on ? r.seg[di] : 8'h00, dig: on ? ~(4'b0001 << di) : 4'hF,
                    tick: k == 31, cur: 2'(di), k: 8'(k)});
      @(negedge clk);
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 16'h1234, 32'h0,        4'b0001, 2'd3, {8'h06, 8'h5B, 8'h4F, 8'hE6}};
    tbl[1] = '{1'b0, 16'h0,    32'h497F8001, 4'b0000, 2'd1, {8'h49, 8'h7F, 8'h80, 8'h01}};
    tbl[2] = '{1'b1, 16'hFA50, 32'h0,        4'b1010, 2'd2, {8'hF1, 8'h77, 8'hED, 8'h3F}};
    tbl[3] = '{1'b0, 16'h0,    32'h12345678, 4'b1111, 2'd3, {8'h92, 8'hB4, 8'hD6, 8'hF8}};
    tbl[4] = '{1'b1, 16'h8B7C, 32'h0,        4'b0000, 2'd0, {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[5] = '{1'b1, 16'hEDC9, 32'h0,        4'b0100, 2'd3, {8'h79, 8'hDE, 8'h39, 8'h6F}};
    dark = tbl[4];
    upd = tbl[0];
    upd.hex = 16'h5678;
    upd.seg = {8'h6D, 8'h7D, 8'h07, 8'hFF};
    apply(tbl[0]);
    #1 rst_n = 1'b0;
    #2;
    check("rst_seg", 16'(seg_out), 16'h00);
    check("rst_dig", 16'(dig_out), 16'hF);
    check("rst_tick", 16'(frame_tick), 16'h0);
    check("rst_cur", 16'(cur_digit), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(dark, 0, 31);
    run_frame(tbl[0], 0, 31);
    run_frame(tbl[0], 0, 7);
    hex_val = 16'h5678;
    run_frame(tbl[0], 8, 31);
    run_frame(upd, 0, 31);
    for (int i = 0; i < 6; i++) begin
      en = 1'b0;
      apply(tbl[i]);
      push_idle();
      @(negedge clk);
      en = 1'b1;
      run_frame(tbl[i], 0, 31);
    end
    run_frame(tbl[5], 0, 17);
    en = 1'b0;
    apply(tbl[1]);
    push_idle();
    @(negedge clk);
    en = 1'b1;
    run_frame(tbl[1], 0, 31);
    run_frame(tbl[1], 0, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 16'(seg_out), 16'h00);
    check("arst_dig", 16'(dig_out), 16'hF);
    check("arst_cur", 16'(cur_digit), 16'h0);
    repeat (3) @(negedge clk);
    check("queue_drained", 16'(q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
